// File: rtl/serializador.sv
// Byte-to-bit serializer: 4-entry byte FIFO feeding an MSB-first
// strobed bit stream with downstream back-pressure.
`timescale 1ns/1ps
module serializador (
  input  logic       clk_100KHz,
  input  logic       reset,
  input  logic [7:0] data_in,
  input  logic       valid_in,
  output logic       ready_out,
  input  logic       status_in,
  output logic       data_out,
  output logic       write_out,
  output logic       busy_out,
  output logic [2:0] fifo_count
);

  typedef enum logic [1:0] {
    IDLE,
    SEND,
    GAP
  } state_t;

  state_t     state;
  logic [7:0] mem [4];
  logic [1:0] wr_ptr;
  logic [1:0] rd_ptr;
  logic [7:0] shift;
  logic [2:0] bit_idx;
  logic [7:0] head;
  logic       push;
  logic       pop;
  logic [2:0] count_nxt;

  assign head = mem[rd_ptr];

  // Push is refused when full, even if a pop happens in the same cycle
  always_comb begin
    push      = valid_in && (fifo_count != 3'd4);
    pop       = (state == IDLE) && (fifo_count != 3'd0) && !status_in;
    count_nxt = fifo_count;
    if (push && !pop)
      count_nxt = fifo_count + 3'd1;
    else if (!push && pop)
      count_nxt = fifo_count - 3'd1;
  end

  // Storage array; contents need no reset since the pointers guard them
  always_ff @(posedge clk_100KHz) begin
    if (push)
      mem[wr_ptr] <= data_in;
  end

  // Pointers, occupancy and registered ready flag
  always_ff @(posedge clk_100KHz) begin
    if (reset) begin
      wr_ptr     <= 2'd0;
      rd_ptr     <= 2'd0;
      fifo_count <= 3'd0;
      ready_out  <= 1'b1;
    end else begin
      if (push)
        wr_ptr <= wr_ptr + 2'd1;
      if (pop)
        rd_ptr <= rd_ptr + 2'd1;
      fifo_count <= count_nxt;
      ready_out  <= (count_nxt != 3'd4);
    end
  end

  // Bit sequencer: one strobe cycle, then at least one gap cycle per bit
  always_ff @(posedge clk_100KHz) begin
    if (reset) begin
      state     <= IDLE;
      shift     <= 8'd0;
      bit_idx   <= 3'd0;
      write_out <= 1'b0;
      data_out  <= 1'b0;
      busy_out  <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (pop) begin
            shift     <= head;
            bit_idx   <= 3'd7;
            write_out <= 1'b1;
            data_out  <= head[7];
            busy_out  <= 1'b1;
            state     <= SEND;
          end
        end
        SEND: begin
          write_out <= 1'b0;
          data_out  <= shift[7];
          state     <= GAP;
        end
        GAP: begin
          if (bit_idx == 3'd0) begin
            busy_out <= 1'b0;
            state    <= IDLE;
          end else if (!status_in) begin
            shift     <= {shift[6:0], 1'b0};
            bit_idx   <= bit_idx - 3'd1;
            write_out <= 1'b1;
            data_out  <= shift[6];
            state     <= SEND;
          end
        end
        default: begin
          write_out <= 1'b0;
          busy_out  <= 1'b0;
          state     <= IDLE;
        end
      endcase
    end
  end

endmodule
